// File: rtl/clk_ratio_meter_if.sv
// Handshake/status bundle between the ratio meter and its consumer.
// The consumer drives the monitored clock and enable; the meter returns measurements and status.
interface clk_ratio_meter_if #(
  parameter int unsigned CNT_W = 8
);
  logic             clk_mon;
  logic             enable;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             locked;
  logic             ratio_change;
  logic             timeout_err;

  modport master (
    output clk_mon, enable,
    input  period, high_time, meas_valid, locked, ratio_change, timeout_err
  );

  modport slave (
    input  clk_mon, enable,
    output period, high_time, meas_valid, locked, ratio_change, timeout_err
  );
endinterface

// File: rtl/clk_ratio_meter.sv
// Measures period and high time of a clock derived from clk_in, in clk_in cycles.
// Declares lock after LOCK_CNT equal periods; flags ratio changes and a lost clock.
module clk_ratio_meter #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned TIMEOUT  = 200
) (
  input  logic                clk_in,
  input  logic                rst_n,
  clk_ratio_meter_if.slave    mon_bus
);

  localparam int unsigned MATCH_W = 4;
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]   TMO_VAL   = CNT_W'(TIMEOUT);
  localparam logic [MATCH_W-1:0] MATCH_MAX = '1;
  localparam logic [MATCH_W-1:0] MATCH_ONE = MATCH_W'(1);
  localparam logic [MATCH_W-1:0] LOCK_VAL  = MATCH_W'(LOCK_CNT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_MEASURE,
    S_LOCKED
  } state_t;

  state_t             r_state;
  logic               r_sync1;
  logic               r_sync2;
  logic               r_s_d;
  logic [CNT_W-1:0]   r_pcnt;
  logic [CNT_W-1:0]   r_hcnt;
  logic [CNT_W-1:0]   r_period;
  logic [CNT_W-1:0]   r_high;
  logic               r_meas_valid;
  logic               r_locked;
  logic               r_ratio_change;
  logic               r_timeout_err;
  logic [MATCH_W-1:0] r_match;

  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_pcnt_nxt;
  logic [CNT_W-1:0]   w_hcnt_nxt;
  logic [CNT_W-1:0]   w_period_nxt;
  logic [CNT_W-1:0]   w_high_nxt;
  logic               w_meas_valid_nxt;
  logic               w_locked_nxt;
  logic               w_ratio_change_nxt;
  logic               w_timeout_err_nxt;
  logic [MATCH_W-1:0] w_match_nxt;

  logic               w_rise;
  logic               w_same;
  logic               w_tmo;
  logic [CNT_W-1:0]   w_pcnt_inc;
  logic [CNT_W-1:0]   w_hcnt_inc;
  logic [MATCH_W-1:0] w_match_cap;

  // Two-flop synchronizer plus edge-detect delay; runs regardless of enable
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_s_d   <= 1'b0;
    end else begin
      r_sync1 <= mon_bus.clk_mon;
      r_sync2 <= r_sync1;
      r_s_d   <= r_sync2;
    end
  end

  assign w_rise      = r_sync2 & ~r_s_d;
  assign w_same      = (r_pcnt == r_period);
  assign w_tmo       = ~w_rise & (r_pcnt == TMO_VAL);
  assign w_pcnt_inc  = (r_pcnt == CNT_MAX) ? r_pcnt : r_pcnt + CNT_ONE;
  assign w_hcnt_inc  = (r_hcnt == CNT_MAX) ? r_hcnt : r_hcnt + CNT_ONE;
  // Match count after a capture; a count of 0 (fresh start) always yields 1
  assign w_match_cap = w_same ? ((r_match == MATCH_MAX) ? r_match : r_match + MATCH_ONE)
                              : MATCH_ONE;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_pcnt         <= '0;
      r_hcnt         <= '0;
      r_period       <= '0;
      r_high         <= '0;
      r_meas_valid   <= 1'b0;
      r_locked       <= 1'b0;
      r_ratio_change <= 1'b0;
      r_timeout_err  <= 1'b0;
      r_match        <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_pcnt         <= w_pcnt_nxt;
      r_hcnt         <= w_hcnt_nxt;
      r_period       <= w_period_nxt;
      r_high         <= w_high_nxt;
      r_meas_valid   <= w_meas_valid_nxt;
      r_locked       <= w_locked_nxt;
      r_ratio_change <= w_ratio_change_nxt;
      r_timeout_err  <= w_timeout_err_nxt;
      r_match        <= w_match_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_pcnt_nxt         = w_rise ? CNT_ONE : w_pcnt_inc;
    w_hcnt_nxt         = w_rise ? CNT_ONE : (r_sync2 ? w_hcnt_inc : r_hcnt);
    w_period_nxt       = r_period;
    w_high_nxt         = r_high;
    w_meas_valid_nxt   = 1'b0;
    w_locked_nxt       = r_locked;
    w_ratio_change_nxt = 1'b0;
    w_timeout_err_nxt  = r_timeout_err;
    w_match_nxt        = r_match;

    if (!mon_bus.enable) begin
      w_state_nxt       = S_IDLE;
      w_pcnt_nxt        = '0;
      w_hcnt_nxt        = '0;
      w_period_nxt      = '0;
      w_high_nxt        = '0;
      w_locked_nxt      = 1'b0;
      w_timeout_err_nxt = 1'b0;
      w_match_nxt       = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_ARM;
          w_pcnt_nxt  = '0;
          w_hcnt_nxt  = '0;
        end
        S_ARM: begin
          if (w_rise) begin
            w_state_nxt = S_MEASURE;
          end
        end
        S_MEASURE: begin
          if (w_rise) begin
            w_period_nxt     = r_pcnt;
            w_high_nxt       = r_hcnt;
            w_meas_valid_nxt = 1'b1;
            w_match_nxt      = w_match_cap;
            if (w_match_cap == LOCK_VAL) begin
              w_locked_nxt = 1'b1;
              w_state_nxt  = S_LOCKED;
            end
          end
        end
        S_LOCKED: begin
          if (w_rise) begin
            w_period_nxt     = r_pcnt;
            w_high_nxt       = r_hcnt;
            w_meas_valid_nxt = 1'b1;
            if (!w_same) begin
              w_locked_nxt       = 1'b0;
              w_ratio_change_nxt = 1'b1;
              w_match_nxt        = MATCH_ONE;
              w_state_nxt        = S_MEASURE;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase

      // Lost clock: re-arm so the next rise starts a fresh measurement
      if (r_state != S_IDLE && w_tmo) begin
        w_timeout_err_nxt = 1'b1;
        w_locked_nxt      = 1'b0;
        w_match_nxt       = '0;
        w_pcnt_nxt        = '0;
        w_state_nxt       = S_ARM;
      end
    end
  end

  assign mon_bus.period       = r_period;
  assign mon_bus.high_time    = r_high;
  assign mon_bus.meas_valid   = r_meas_valid;
  assign mon_bus.locked       = r_locked;
  assign mon_bus.ratio_change = r_ratio_change;
  assign mon_bus.timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Directed bench for clk_ratio_meter: table of divider settings with expected captures,
// plus hand sequences for clock loss, enable drop and asynchronous reset.
module tb_clk_ratio_meter;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned LOCK_CNT = 4;
  localparam int unsigned TIMEOUT  = 200;
  localparam int NV = 22;

  typedef struct {
    int req_n;
    int period;
    int high;
    int locked;
    int rc;
    int terr;
  } vec_t;

  logic clk_in = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  int   gen_req  = 0;
  int   cur_n    = 0;
  int   phase    = 0;
  vec_t vecs [NV];

  clk_ratio_meter_if #(.CNT_W(CNT_W)) mon_bus ();

  clk_ratio_meter #(
    .CNT_W   (CNT_W),
    .LOCK_CNT(LOCK_CNT),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .mon_bus(mon_bus)
  );

  always #5 clk_in = ~clk_in;

  // Divide-by-N source; a new ratio takes effect only at a period boundary, 0 = stopped
  initial begin
    mon_bus.clk_mon = 1'b0;
    forever begin
      @(negedge clk_in);
      if (phase == 0) cur_n = gen_req;
      if (cur_n == 0) begin
        mon_bus.clk_mon = 1'b0;
      end else begin
        mon_bus.clk_mon = (phase < cur_n / 2);
        phase = (phase + 1) % cur_n;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_period"},    int'(mon_bus.period), 0);
    chk({tag, "_high"},      int'(mon_bus.high_time), 0);
    chk({tag, "_valid"},     int'(mon_bus.meas_valid), 0);
    chk({tag, "_locked"},    int'(mon_bus.locked), 0);
    chk({tag, "_rc"},        int'(mon_bus.ratio_change), 0);
    chk({tag, "_terr"},      int'(mon_bus.timeout_err), 0);
  endtask

  task automatic wait_valid(input string tag);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(posedge clk_in);
      #1;
      if (mon_bus.meas_valid) got = 1'b1;
      else if (mon_bus.ratio_change) chk({tag, "_rc_without_valid"}, int'(mon_bus.ratio_change), 0);
    end
    if (!got) chk({tag, "_valid_wait"}, int'(got), 1);
  endtask

  task automatic run_rows(input int lo, input int hi);
    string tag;
    for (int i = lo; i <= hi; i++) begin
      tag = $sformatf("row%0d", i);
      gen_req = vecs[i].req_n;
      wait_valid(tag);
      chk({tag, "_period"}, int'(mon_bus.period),       vecs[i].period);
      chk({tag, "_high"},   int'(mon_bus.high_time),    vecs[i].high);
      chk({tag, "_locked"}, int'(mon_bus.locked),       vecs[i].locked);
      chk({tag, "_rc"},     int'(mon_bus.ratio_change), vecs[i].rc);
      chk({tag, "_terr"},   int'(mon_bus.timeout_err),  vecs[i].terr);
    end
  endtask

  initial begin
    int  cnt;
    bit  seen;

    // /4 from enable: lock on 4th capture
    vecs[0]  = '{4, 4, 2, 0, 0, 0};
    vecs[1]  = '{4, 4, 2, 0, 0, 0};
    vecs[2]  = '{4, 4, 2, 0, 0, 0};
    vecs[3]  = '{4, 4, 2, 1, 0, 0};
    // switch to /6: last /4 period, then one ratio_change, relock after 4
    vecs[4]  = '{6, 4, 2, 1, 0, 0};
    vecs[5]  = '{6, 6, 3, 0, 1, 0};
    vecs[6]  = '{6, 6, 3, 0, 0, 0};
    vecs[7]  = '{6, 6, 3, 0, 0, 0};
    vecs[8]  = '{6, 6, 3, 1, 0, 0};
    // switch to odd /3: high time 1
    vecs[9]  = '{3, 6, 3, 1, 0, 0};
    vecs[10] = '{3, 3, 1, 0, 1, 0};
    vecs[11] = '{3, 3, 1, 0, 0, 0};
    vecs[12] = '{3, 3, 1, 0, 0, 0};
    vecs[13] = '{3, 3, 1, 1, 0, 0};
    // restart after clock loss: timeout_err stays set
    vecs[14] = '{3, 3, 1, 0, 0, 1};
    vecs[15] = '{3, 3, 1, 0, 0, 1};
    vecs[16] = '{3, 3, 1, 0, 0, 1};
    vecs[17] = '{3, 3, 1, 1, 0, 1};
    // re-enable after idle: partial period discarded, counts from scratch
    vecs[18] = '{3, 3, 1, 0, 0, 0};
    vecs[19] = '{3, 3, 1, 0, 0, 0};
    vecs[20] = '{3, 3, 1, 0, 0, 0};
    vecs[21] = '{3, 3, 1, 1, 0, 0};

    rst_n = 1'b0;
    mon_bus.enable = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    chk_cleared("reset");
    rst_n = 1'b1;
    @(posedge clk_in);
    #1;
    mon_bus.enable = 1'b1;

    run_rows(0, 3);
    run_rows(4, 8);
    run_rows(9, 13);

    // Stop the clock: timeout exactly TIMEOUT cycles after the last capture
    gen_req = 0;
    cnt = 0;
    seen = 1'b0;
    for (int c = 0; c < 600 && !seen; c++) begin
      @(posedge clk_in);
      #1;
      if (mon_bus.meas_valid) cnt = 0;
      else cnt++;
      if (mon_bus.timeout_err) seen = 1'b1;
    end
    chk("tmo_cycles", cnt, int'(TIMEOUT));
    chk("tmo_locked", int'(mon_bus.locked), 0);
    chk("tmo_valid", int'(mon_bus.meas_valid), 0);
    repeat (5) @(posedge clk_in);
    #1;
    chk("tmo_sticky", int'(mon_bus.timeout_err), 1);

    run_rows(14, 17);

    // Drop enable mid-period: everything clears on the next cycle
    @(posedge clk_in);
    #1;
    mon_bus.enable = 1'b0;
    @(posedge clk_in);
    #1;
    chk_cleared("disable");
    repeat (4) @(posedge clk_in);
    #1;
    mon_bus.enable = 1'b1;
    run_rows(18, 21);

    // Asynchronous reset while locked, checked before any clk_in edge
    @(posedge clk_in);
    #2;
    chk("pre_rst_locked", int'(mon_bus.locked), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_locked", int'(mon_bus.locked), 0);
    chk("async_rst_period", int'(mon_bus.period), 0);
    chk("async_rst_high", int'(mon_bus.high_time), 0);
    chk("async_rst_valid", int'(mon_bus.meas_valid), 0);
    #20;
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
